// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter, issues one fetch at a time to the
// instruction manager unit and hands the returned word to decode through a
// valid/ready handshake. Redirects from execute replace the PC at any time,
// and a response already in flight is dropped when it returns.
//
// Optional feature macro: FETCH_SEQ_ALIGN_CHECK_EN
//   defined   - a misaligned redirect parks the sequencer in FAULT (out_fault=1)
//   undefined - redirect_pc[1:0] is forced to 2'b00, out_fault is tied low
//
// state | meaning
// ISSUE | idle; issues a fetch as soon as the IMU is ready (also drains a stale response after reset)
// BUSY  | one fetch outstanding at the IMU
// HOLD  | instruction presented to decode, waiting for out_ready
// FAULT | misaligned redirect taken; no fetches until an aligned redirect
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imu_ready,
    input  logic [31:0] imu_ir,
    output logic [31:0] imu_pc,
    output logic        imu_fetch,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_ir,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    output logic        out_fault
);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        BUSY  = 2'd1,
        HOLD  = 2'd2
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
        , FAULT = 2'd3
`endif
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        discard;
    logic [31:0] redirect_load;
    state_t      redirect_target;
    state_t      drain_target;

`ifdef FETCH_SEQ_ALIGN_CHECK_EN
    // A misaligned redirect taken while BUSY is remembered here so FAULT is
    // entered only once the dropped response has drained.
    logic fault_pend;
    logic misaligned;

    assign misaligned      = (redirect_pc[1:0] != 2'b00);
    assign redirect_load   = redirect_pc;
    assign redirect_target = misaligned ? FAULT : ISSUE;
    assign drain_target    = fault_pend ? FAULT : ISSUE;
    assign out_fault       = (state == FAULT);
`else
    assign redirect_load   = redirect_pc & 32'hFFFF_FFFC;
    assign redirect_target = ISSUE;
    assign drain_target    = ISSUE;
    assign out_fault       = 1'b0;
`endif

    // Fetch request is a single-cycle pulse; a same-cycle redirect suppresses it.
    assign imu_fetch = !rst && (state == ISSUE) && imu_ready && !redirect_valid;
    assign imu_pc    = pc;

    // Sequencer state, PC and decode-side output registers; redirect has priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ISSUE;
            pc        <= RESET_PC;
            discard   <= 1'b0;
            out_valid <= 1'b0;
            out_ir    <= 32'h0;
            out_pc    <= 32'h0;
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
            fault_pend <= 1'b0;
`endif
        end else if (redirect_valid) begin
            pc <= redirect_load;
            case (state)
                BUSY: begin
                    if (imu_ready) begin
                        discard <= 1'b0;
                        state   <= redirect_target;
                    end else begin
                        discard <= 1'b1;
                    end
                end
                HOLD: begin
                    out_valid <= 1'b0;
                    state     <= redirect_target;
                end
                default: state <= redirect_target;
            endcase
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
            fault_pend <= (state == BUSY) && !imu_ready && misaligned;
`endif
        end else begin
            case (state)
                ISSUE: begin
                    if (imu_fetch) state <= BUSY;
                end
                BUSY: begin
                    if (imu_ready) begin
                        if (discard) begin
                            discard <= 1'b0;
                            state   <= drain_target;
                        end else begin
                            out_ir    <= imu_ir;
                            out_pc    <= pc;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        pc        <= pc + 32'd4;
                        state     <= ISSUE;
                    end
                end
                default: ;
            endcase
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
            if ((state == BUSY) && imu_ready) fault_pend <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: IMU stub with k=3, directed stimulus, and a
// scoreboard monitor checking every fetch address and every decode handshake.
module tb_fetch_sequencer;

    localparam int K = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imu_ready = 1'b1;
    logic [31:0] imu_ir = 32'h0;
    logic [31:0] imu_pc;
    logic        imu_fetch;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic [31:0] out_ir;
    logic [31:0] out_pc;
    logic        out_ready = 1'b0;
    logic        out_fault;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fetch_cyc = 0;

    logic [31:0] exp_fetch[$];
    logic [63:0] exp_out[$];

    fetch_sequencer #(.RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .rst            (rst),
        .imu_ready      (imu_ready),
        .imu_ir         (imu_ir),
        .imu_pc         (imu_pc),
        .imu_fetch      (imu_fetch),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ir         (out_ir),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .out_fault      (out_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0050_0093;
            32'h0000_0104: return 32'h00A0_0113;
            32'h0000_0200: return 32'h00C0_0193;
            32'h0000_0300: return 32'h00E0_0213;
            32'hFFFF_FFFC: return 32'h0100_0293;
            32'h0000_0000: return 32'h0120_0313;
            32'h0000_0400: return 32'h0140_0393;
            default:       return 32'h0000_0013;
        endcase
    endfunction

    // IMU stub: ready drops the cycle after a fetch and returns k cycles after it.
    int          busy_cnt = 0;
    logic [31:0] pend_ir = 32'h0;
    always @(posedge clk) begin
        if (imu_fetch) begin
            imu_ready <= 1'b0;
            busy_cnt  <= K - 1;
            pend_ir   <= imem(imu_pc);
        end else if (busy_cnt == 1) begin
            imu_ready <= 1'b1;
            imu_ir    <= pend_ir;
            busy_cnt  <= 0;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT fetches or hands off.
    always @(negedge clk) begin
        if (!rst) begin
            if (imu_fetch) begin
                fetch_cyc = cyc;
                if (exp_fetch.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected fetch: got imu_pc %h expected no fetch", imu_pc);
                end else begin
                    check("fetch address", imu_pc, exp_fetch.pop_front());
                end
            end
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected accept: got pc %h ir %h expected none", out_pc, out_ir);
                end else begin
                    logic [63:0] e;
                    e = exp_out.pop_front();
                    check("accept ir", out_ir, e[63:32]);
                    check("accept pc", out_pc, e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic accept(input logic [31:0] ir_e, input logic [31:0] pc_e);
        exp_out.push_back({ir_e, pc_e});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic wait_valid(input logic [31:0] pc_e, input logic [31:0] ir_e);
        int n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check("out_valid arrives", {31'h0, out_valid}, 32'h1);
        check("out_pc", out_pc, pc_e);
        check("out_ir", out_ir, ir_e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, and no fetch while rst is high even though the IMU is ready
        repeat (3) tick();
        check("reset imu_fetch", {31'h0, imu_fetch}, 32'h0);
        check("reset out_valid", {31'h0, out_valid}, 32'h0);
        check("reset out_ir", out_ir, 32'h0);
        check("reset out_pc", out_pc, 32'h0);
        check("reset out_fault", {31'h0, out_fault}, 32'h0);
        check("reset imu_pc", imu_pc, 32'h0000_0100);

        // First fetch at RESET_PC, data visible 4 cycles after the fetch pulse
        exp_fetch.push_back(32'h0000_0100);
        rst = 1'b0;
        tick();
        wait_valid(32'h0000_0100, 32'h0050_0093);
        check("first fetch latency", cyc, fetch_cyc + 4);

        // Decode stalls for 5 cycles: outputs hold and nothing is fetched
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall out_valid", {31'h0, out_valid}, 32'h1);
            check("stall out_pc", out_pc, 32'h0000_0100);
            check("stall out_ir", out_ir, 32'h0050_0093);
            check("stall imu_fetch", {31'h0, imu_fetch}, 32'h0);
        end
        exp_fetch.push_back(32'h0000_0104);
        accept(32'h0050_0093, 32'h0000_0100);
        check("fetch cycle after accept", {31'h0, imu_fetch}, 32'h1);

        // Redirect while BUSY: the 0x104 word is dropped, next fetch at 0x200
        tick();
        exp_fetch.push_back(32'h0000_0200);
        redirect(32'h0000_0200);
        wait_valid(32'h0000_0200, 32'h00C0_0193);

        // Redirect in HOLD together with out_ready: accepted, but no pc+4
        exp_fetch.push_back(32'h0000_0300);
        exp_out.push_back({32'h00C0_0193, 32'h0000_0200});
        out_ready = 1'b1;
        redirect(32'h0000_0300);
        out_ready = 1'b0;
        check("hold redirect drops valid", {31'h0, out_valid}, 32'h0);
        wait_valid(32'h0000_0300, 32'h00E0_0213);

        // PC wrap from 0xFFFF_FFFC to 0
        exp_fetch.push_back(32'hFFFF_FFFC);
        redirect(32'hFFFF_FFFC);
        check("hold redirect no accept", {31'h0, out_valid}, 32'h0);
        wait_valid(32'hFFFF_FFFC, 32'h0100_0293);
        exp_fetch.push_back(32'h0000_0000);
        accept(32'h0100_0293, 32'hFFFF_FFFC);
        wait_valid(32'h0000_0000, 32'h0120_0313);

        // Misaligned redirect to 0x202
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
        redirect(32'h0000_0202);
        for (int i = 0; i < 6; i++) begin
            check("fault out_fault", {31'h0, out_fault}, 32'h1);
            check("fault imu_fetch", {31'h0, imu_fetch}, 32'h0);
            tick();
        end
        exp_fetch.push_back(32'h0000_0400);
        redirect(32'h0000_0400);
        check("fault cleared", {31'h0, out_fault}, 32'h0);
`else
        exp_fetch.push_back(32'h0000_0200);
        redirect(32'h0000_0202);
        check("no fault without check", {31'h0, out_fault}, 32'h0);
        wait_valid(32'h0000_0200, 32'h00C0_0193);
        exp_fetch.push_back(32'h0000_0400);
        redirect(32'h0000_0400);
`endif
        wait_valid(32'h0000_0400, 32'h0140_0393);

        // Reset mid-fetch: stale 0x404 response never delivered, refetch at RESET_PC
        exp_fetch.push_back(32'h0000_0404);
        accept(32'h0140_0393, 32'h0000_0400);
        tick();
        exp_fetch.push_back(32'h0000_0100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("reset mid-fetch waits", {31'h0, imu_fetch}, 32'h0);
        wait_valid(32'h0000_0100, 32'h0050_0093);

        repeat (4) tick();
        check("fetch queue drained", exp_fetch.size(), 32'h0);
        check("accept queue drained", exp_out.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Front-end sequencer between the instruction manager unit and the decode stage. It owns the program counter and issues one fetch at a time to the instruction manager unit. It captures the returned instruction word and presents it to decode through a valid/ready handshake. It also applies redirects from execute (branches, jumps, traps), including redirects that arrive while a fetch is in flight.

## Interface
- `RESET_PC`, default 32'h0000_0000: program counter value loaded on reset.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset. Synchronous, active-high.
- `imu_ready` in 1: instruction manager unit is idle; when high after a fetch, `imu_ir` holds the fetched word.
- `imu_ir` in 32: instruction word from the instruction manager unit.
- `imu_pc` out 32: fetch address driven to the instruction manager unit; equals internal PC.
- `imu_fetch` out 1: single-cycle fetch request.
- `redirect_valid` in 1: replace the PC with `redirect_pc` this cycle.
- `redirect_pc` in 32: new program counter.
- `out_valid` out 1: `out_ir`/`out_pc` hold a valid instruction.
- `out_ir` out 32: fetched instruction.
- `out_pc` out 32: address of `out_ir`.
- `out_ready` in 1: decode accepts the instruction when `out_valid && out_ready`.
- `out_fault` out 1: misaligned-redirect fault; see Configuration.

## Operation
- States: ISSUE, BUSY, HOLD, FAULT. FAULT exists only with the macro defined.
- Registers: `pc`, `out_ir`, `out_pc`, `out_valid`, `discard`, `state`.
- Combinational outputs:
  - `imu_fetch = !rst && state==ISSUE && imu_ready && !redirect_valid`.
  - `imu_pc = pc`.
- ISSUE:
  - With `imu_fetch` high, go to BUSY.
  - Otherwise wait here. This includes waiting for a stale response to drain after reset.
- BUSY:
  - With `imu_ready` high and `discard` low, capture `out_ir<=imu_ir` and `out_pc<=pc`, set `out_valid<=1`, and go to HOLD.
  - With `imu_ready` high and `discard` high, drop the word, clear `discard`, and go to ISSUE.
- HOLD:
  - On `out_valid && out_ready`: `out_valid<=0`, `pc<=pc+4` (mod 2^32, wraps), go to ISSUE.
- Redirect: `redirect_valid` has priority over every transition above.
  - It always sets `pc<=redirect_pc`.
  - In ISSUE: no fetch is issued; stay in ISSUE.
  - In BUSY: set `discard<=1` and stay in BUSY. If `imu_ready` is also high that cycle, drop the word and go to ISSUE with `discard` cleared.
  - In HOLD: `out_valid<=0`, go to ISSUE. If `out_ready` was also high, the handshake still counts as accepted by decode, but `pc+4` is not applied.
- Back-to-back redirects: the last one wins. At most one response is ever discarded per outstanding fetch.

## Timing
- Reset values: `pc=RESET_PC`, state ISSUE, `out_valid=0`, `out_ir=0`, `out_pc=0`, `discard=0`, `out_fault=0`. `imu_fetch` is 0 during every `rst` cycle.
- Fetch pulse in cycle N: the instruction manager drops `imu_ready` in N+1 and raises it in N+k when data is ready. `out_valid` is high in N+k+1.
- Accept in cycle M: the next `imu_fetch` comes in M+1.
- Throughput: one instruction per k+2 cycles when decode never stalls.
- Outputs `out_ir`/`out_pc` stay stable while `out_valid && !out_ready`.
- Reset mid-fetch: the sequencer returns to ISSUE and waits for `imu_ready`. It issues no fetch until the outstanding response completes, and that response is never delivered.

## Configuration
- Macro: `FETCH_SEQ_ALIGN_CHECK_EN`.
- Defined: a redirect with `redirect_pc[1:0]!=0` loads `pc`, invalidates HOLD, sets `discard` if BUSY, then enters FAULT.
  - If the redirect arrives while BUSY, FAULT is entered only after the discarded response drains.
  - In FAULT: `out_fault=1` and no fetches are issued.
  - FAULT is left only by an aligned redirect (go to ISSUE, `out_fault<=0`) or by reset.
- Undefined: `redirect_pc[1:0]` is forced to 2'b00 on load, the FAULT state is absent, and `out_fault` is tied to 0.

## Test plan
- Reset with `RESET_PC`=32'h100 and an instruction manager stub with k=3 returning 32'h00500093 -> first `imu_fetch` has `imu_pc`=32'h100. In cycle N+4, `out_valid`=1, `out_ir`=32'h00500093, `out_pc`=32'h100.
- Decode holds `out_ready`=0 for 5 cycles, then 1 -> outputs stable for 5 cycles, no fetch issued; the next fetch uses `imu_pc`=32'h104.
- Redirect to 32'h200 while BUSY -> the in-flight word is dropped, `out_valid` stays 0, and the next fetch uses 32'h200.
- Redirect to 32'h300 in HOLD in the same cycle as `out_ready`=1 -> `out_valid` falls, the next fetch uses 32'h300, not `out_pc`+4.
- `pc`=32'hFFFF_FFFC accepted -> the next fetch uses 32'h0000_0000.
- With the macro defined, redirect to 32'h202 -> `out_fault`=1, no `imu_fetch`. A later redirect to 32'h400 -> `out_fault`=0 and a fetch at 32'h400. With the macro undefined, the same redirect fetches at 32'h200.
